pc_fetch_unit: RTL and testbench

- Program-counter stage directly downstream of the branch-decision gate. It consumes PCSrc (zero & branch), jump control and immediate fields, and produces the next PC.
- Holds the PC register and computes PC+4, branch target and jump target.
- Drives a req/ack fetch handshake to instruction memory, honours a pipeline stall, and keeps a saturating taken-branch counter for debug.

---
 rtl/pc_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: holds the PC, selects the next PC from jump /
// branch / sequential targets, runs the req/ack fetch handshake towards
// instruction memory, parks a resolved next-PC while the pipeline is
// stalled, and counts applied taken branches (saturating) for debug.
//
// Handshake: if_req is registered and high only while the unit is in
// FETCH. An instruction completes on a rising edge where if_req=1 and
// if_ack=1. if_ack is ignored in every other cycle, and PCSrc, jump and
// the immediate fields are only sampled on that completing edge.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCSrc,
  input  logic [31:0]      branch_offset,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             stall,
  input  logic             if_ack,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             if_req,
  output logic [CNT_W-1:0] branch_count,
  output logic             misalign,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t      state;
  state_t      state_d;
  logic [31:0] hold_pc;
  logic        hold_br;

  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] next_pc;
  logic        take_br;

  logic        pc_load;
  logic [31:0] pc_val;
  logic        cnt_inc;
  logic        hold_load;
  logic        req_d;

  // Target arithmetic and next-PC priority (jump over branch over +4).
  always_comb begin
    pc_plus4   = pc + 32'd4;
    br_target  = pc_plus4 + (branch_offset << 2);
    jmp_target = {pc_plus4[31:28], jump_index, 2'b00};
    take_br    = PCSrc & ~jump;
    if (jump)         next_pc = jmp_target;
    else if (take_br) next_pc = br_target;
    else              next_pc = pc_plus4;
    misalign   = |pc[1:0];
    fsm_state  = state;
  end

  // Next-state and commit decisions for the fetch handshake.
  always_comb begin
    state_d   = state;
    pc_load   = 1'b0;
    pc_val    = next_pc;
    cnt_inc   = 1'b0;
    hold_load = 1'b0;
    req_d     = if_req;
    case (state)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        if (if_ack) begin
          if (!stall) begin
            pc_load = 1'b1;
            pc_val  = next_pc;
            cnt_inc = take_br;
          end else begin
            hold_load = 1'b1;
            req_d     = 1'b0;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          pc_load = 1'b1;
          pc_val  = hold_pc;
          cnt_inc = hold_br;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // PC and fetch request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      if_req <= 1'b0;
    end else begin
      if (pc_load) pc <= pc_val;
      if_req <= req_d;
    end
  end

  // Next-PC parked while a completed instruction waits out a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_pc <= 32'h0000_0000;
      hold_br <= 1'b0;
    end else if (hold_load) begin
      hold_pc <= next_pc;
      hold_br <= take_br;
    end
  end

  // Saturating count of taken branches committed to pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                branch_count <= '0;
    else if (cnt_inc && branch_count != CNT_MAX) branch_count <= branch_count + CNT_ONE;
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCSrc;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        stall;
  logic        if_ack;

  logic [31:0] pc, pc_plus4, pc_b, pc_plus4_b;
  logic        if_req, misalign, if_req_b, misalign_b;
  logic [15:0] branch_count;
  logic [1:0]  branch_count_b;
  logic [1:0]  fsm_state, fsm_state_b;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_req;
  int          m_mode;      // 0 = dead cycle, 1 = fetching, 2 = parked by stall
  logic [31:0] m_hold_pc;
  logic        m_hold_br;
  logic [15:0] m_cnt;
  logic [1:0]  m_cnt2;

  pc_fetch_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .stall(stall), .if_ack(if_ack),
    .pc(pc), .pc_plus4(pc_plus4), .if_req(if_req), .branch_count(branch_count),
    .misalign(misalign), .fsm_state(fsm_state));

  pc_fetch_unit #(.RESET_PC(32'h0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .branch_offset(branch_offset),
    .jump(jump), .jump_index(jump_index), .stall(stall), .if_ack(if_ack),
    .pc(pc_b), .pc_plus4(pc_plus4_b), .if_req(if_req_b), .branch_count(branch_count_b),
    .misalign(misalign_b), .fsm_state(fsm_state_b));

  // Clock
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_req = 1'b0; m_mode = 0;
    m_hold_pc = 32'h0; m_hold_br = 1'b0; m_cnt = 16'h0; m_cnt2 = 2'd0;
  endtask

  task automatic model_count();
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (m_cnt2 != 2'd3)    m_cnt2 = m_cnt2 + 2'd1;
  endtask

  // Drive one cycle of inputs (from posedge+1), advance through the edge,
  // and move the reference model by the same edge.
  task automatic step(input logic ack, input logic stl, input logic src,
                      input logic jmp, input logic [31:0] off, input logic [25:0] idx);
    logic [31:0] seq, nxt;
    logic        tb;
    if_ack = ack; stall = stl; PCSrc = src; jump = jmp;
    branch_offset = off; jump_index = idx;
    seq = m_pc + 32'd4;
    tb  = src && !jmp;
    if (jmp)     nxt = {seq[31:28], idx, 2'b00};
    else if (tb) nxt = seq + off * 32'd4;
    else         nxt = seq;
    @(posedge clk); #1;
    case (m_mode)
      0: begin m_mode = 1; m_req = 1'b1; end
      1: if (ack) begin
        if (!stl) begin
          m_pc = nxt;
          if (tb) model_count();
        end else begin
          m_hold_pc = nxt; m_hold_br = tb; m_req = 1'b0; m_mode = 2;
        end
      end
      default: if (!stl) begin
        m_pc = m_hold_pc;
        if (m_hold_br) model_count();
        m_req = 1'b1; m_mode = 1;
      end
    endcase
  endtask

  // Branch from the current pc to an aligned target in one fetch.
  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] diff;
    for (int i = 0; i < 4 && m_mode != 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    diff = target - (m_pc + 32'd4);
    step(1'b1, 1'b0, 1'b1, 1'b0, {{2{diff[31]}}, diff[31:2]}, 26'h0);
  endtask

  task automatic test_reset();
    n_total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); else n_pass++;
    n_total++; if (if_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", if_req); else n_pass++;
    n_total++; if (branch_count !== 16'h0) $display("FAIL reset_cnt: got %h expected 0", branch_count); else n_pass++;
    rst_n = 1'b1;
    n_total++; if (if_req !== 1'b0) $display("FAIL release_req: got %b expected 0", if_req); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8; exp_seq[3] = 32'hC;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);  // dead cycle, ack ignored
    n_total++; if (if_req !== 1'b1) $display("FAIL seq_req_up: got %b expected 1", if_req); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (pc !== exp_seq[i]) $display("FAIL seq_pc%0d: got %h expected %h", i, pc, exp_seq[i]); else n_pass++;
      if (i < 3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    end
    n_total++; if (branch_count !== 16'h0) $display("FAIL seq_cnt: got %h expected 0", branch_count); else n_pass++;
  endtask

  task automatic test_branch();
    logic [15:0] c0;
    goto_pc(32'h100);
    n_total++; if (pc !== 32'h100) $display("FAIL br_goto: got %h expected %h", pc, 32'h100); else n_pass++;
    c0 = m_cnt;
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFE, 26'h0);
    n_total++; if (pc !== 32'h0FC) $display("FAIL br_back: got %h expected %h", pc, 32'h0FC); else n_pass++;
    n_total++; if (branch_count !== c0 + 16'd1) $display("FAIL br_cnt1: got %h expected %h", branch_count, c0 + 16'd1); else n_pass++;
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 26'h0);
    n_total++; if (pc !== 32'h10C) $display("FAIL br_fwd: got %h expected %h", pc, 32'h10C); else n_pass++;
    n_total++; if (branch_count !== c0 + 16'd2) $display("FAIL br_cnt2: got %h expected %h", branch_count, c0 + 16'd2); else n_pass++;
  endtask

  task automatic test_jump();
    logic [15:0] c0;
    goto_pc(32'h4000_0010);
    c0 = m_cnt;
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'd7, 26'h0000040);
    n_total++; if (pc !== 32'h4000_0100) $display("FAIL jump_pc: got %h expected %h", pc, 32'h4000_0100); else n_pass++;
    n_total++; if (branch_count !== c0) $display("FAIL jump_cnt: got %h expected %h", branch_count, c0); else n_pass++;
  endtask

  task automatic test_stall();
    logic [15:0] c0;
    goto_pc(32'h20);
    c0 = m_cnt;
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 26'h0);
    for (int i = 0; i < 3; i++) begin
      n_total++; if (pc !== 32'h20) $display("FAIL stall_pc%0d: got %h expected %h", i, pc, 32'h20); else n_pass++;
      n_total++; if (if_req !== 1'b0) $display("FAIL stall_req%0d: got %b expected 0", i, if_req); else n_pass++;
      // inputs other than stall are ignored while parked
      if (i < 2) step(1'b1, 1'b1, 1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), $urandom, 26'($urandom));
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'd9, 26'h3FF_FFFF);
    n_total++; if (pc !== 32'h34) $display("FAIL stall_exit_pc: got %h expected %h", pc, 32'h34); else n_pass++;
    n_total++; if (if_req !== 1'b1) $display("FAIL stall_exit_req: got %b expected 1", if_req); else n_pass++;
    n_total++; if (branch_count !== c0 + 16'd1) $display("FAIL stall_cnt: got %h expected %h", branch_count, c0 + 16'd1); else n_pass++;
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    n_total++; if (branch_count !== c0 + 16'd1) $display("FAIL stall_cnt_once: got %h expected %h", branch_count, c0 + 16'd1); else n_pass++;
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    n_total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_plus4: got %h expected 0", pc_plus4); else n_pass++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    n_total++; if (pc !== 32'h0) $display("FAIL wrap_pc: got %h expected 0", pc); else n_pass++;
  endtask

  task automatic test_wait();
    logic [31:0] p0;
    p0 = m_pc;
    for (int i = 0; i < 3; i++) step(1'b0, 1'(i % 2), 1'b1, 1'b0, 32'd5, 26'h0);
    n_total++; if (pc !== p0) $display("FAIL wait_pc: got %h expected %h", pc, p0); else n_pass++;
    n_total++; if (if_req !== 1'b1) $display("FAIL wait_req: got %b expected 1", if_req); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
           32'($urandom_range(0, 64)) - 32'd32, 26'($urandom));
      n_total++; if (pc !== m_pc) $display("FAIL rnd_pc@%0d: got %h expected %h", i, pc, m_pc); else n_pass++;
      n_total++; if (pc_plus4 !== m_pc + 32'd4) $display("FAIL rnd_plus4@%0d: got %h expected %h", i, pc_plus4, m_pc + 32'd4); else n_pass++;
      n_total++; if (if_req !== m_req) $display("FAIL rnd_req@%0d: got %b expected %b", i, if_req, m_req); else n_pass++;
      n_total++; if (branch_count !== m_cnt) $display("FAIL rnd_cnt@%0d: got %h expected %h", i, branch_count, m_cnt); else n_pass++;
      n_total++; if (branch_count_b !== m_cnt2) $display("FAIL rnd_cnt2@%0d: got %h expected %h", i, branch_count_b, m_cnt2); else n_pass++;
      n_total++; if (misalign !== |m_pc[1:0]) $display("FAIL rnd_misalign@%0d: got %b expected %b", i, misalign, |m_pc[1:0]); else n_pass++;
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 4 && m_mode != 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'($urandom_range(0, 8)), 26'h0);
    n_total++; if (branch_count_b !== 2'd3) $display("FAIL sat_cnt2: got %h expected 3", branch_count_b); else n_pass++;
    n_total++; if (branch_count !== m_cnt) $display("FAIL sat_cnt16: got %h expected %h", branch_count, m_cnt); else n_pass++;
    n_total++; if (pc_b !== m_pc) $display("FAIL sat_pc: got %h expected %h", pc_b, m_pc); else n_pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4 && m_mode != 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    if_ack = 1'b1; stall = 1'b0; PCSrc = 1'b1; branch_offset = 32'd8;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_total++; if (pc !== 32'h0) $display("FAIL async_pc: got %h expected 0", pc); else n_pass++;
    n_total++; if (if_req !== 1'b0) $display("FAIL async_req: got %b expected 0", if_req); else n_pass++;
    n_total++; if (branch_count !== 16'h0) $display("FAIL async_cnt: got %h expected 0", branch_count); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (pc !== 32'h0) $display("FAIL async_hold_pc: got %h expected 0", pc); else n_pass++;
    rst_n = 1'b1;
    n_total++; if (if_req !== 1'b0) $display("FAIL async_rel_req: got %b expected 0", if_req); else n_pass++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    n_total++; if (if_req !== 1'b1 || pc !== 32'h0) $display("FAIL async_dead: got req=%b pc=%h expected req=1 pc=0", if_req, pc); else n_pass++;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 26'h0);
    n_total++; if (pc !== 32'h4) $display("FAIL async_next: got %h expected 4", pc); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; PCSrc = 1'b0; branch_offset = 32'h0; jump = 1'b0;
    jump_index = 26'h0; stall = 1'b0; if_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_wait();
    test_random();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
